// File: rtl/pwr_seq.sv
// Four-rail power sequencer: ordered bring-up with power-good timeout,
// settle delay per rail, monitored run, stepped shutdown and retry.
module pwr_seq #(
    parameter logic [31:0] MAIN_CLOCK_PERIOD = 32'd7,
    parameter logic [31:0] STEP_DELAY        = 32'd1000000,
    parameter logic [31:0] PG_TIMEOUT        = 32'd10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pg,
    input  logic       retry,
    output logic [3:0] en,
    output logic       ready,
    output logic       fault,
    output logic [1:0] fault_stage
);

    localparam logic [31:0] STEP_RAW  = STEP_DELAY / MAIN_CLOCK_PERIOD;
    localparam logic [31:0] TMO_RAW   = PG_TIMEOUT / MAIN_CLOCK_PERIOD;
    localparam logic [31:0] STEP_CLK  = (STEP_RAW == 32'd0) ? 32'd1 : STEP_RAW;
    localparam logic [31:0] TMO_CLK   = (TMO_RAW == 32'd0) ? 32'd1 : TMO_RAW;
    localparam logic [31:0] STEP_LAST = STEP_CLK - 32'd1;
    localparam logic [31:0] TMO_LAST  = TMO_CLK - 32'd1;
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ENABLE,
        WAIT_PG,
        SETTLE,
        RUN,
        SHUTDOWN,
        FAULT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  en_q;
    logic [3:0]  en_d;
    logic        ready_q;
    logic        ready_d;
    logic        fault_q;
    logic        fault_d;
    logic [1:0]  stage_q;
    logic [1:0]  stage_d;
    logic [1:0]  k_q;
    logic [1:0]  k_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] cnt_inc;
    logic [3:0]  pg_m;
    logic [3:0]  pg_s;
    logic        trip;
    logic [1:0]  trip_idx;
    logic [3:0]  seen;
    logic [3:0]  en_drop;

    // Rails strictly below idx.
    function automatic logic [3:0] below_mask(input logic [1:0] idx);
        below_mask = 4'b0000;
        unique case (idx)
            2'd0: below_mask = 4'b0000;
            2'd1: below_mask = 4'b0001;
            2'd2: below_mask = 4'b0011;
            2'd3: below_mask = 4'b0111;
        endcase
    endfunction

    // Rails up to and including idx.
    function automatic logic [3:0] upto_mask(input logic [1:0] idx);
        upto_mask = 4'b0000;
        unique case (idx)
            2'd0: upto_mask = 4'b0001;
            2'd1: upto_mask = 4'b0011;
            2'd2: upto_mask = 4'b0111;
            2'd3: upto_mask = 4'b1111;
        endcase
    endfunction

    // Index of the lowest zero bit; callers guarantee one exists.
    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        lowest_low = 2'd3;
        if (!v[0]) begin
            lowest_low = 2'd0;
        end else if (!v[1]) begin
            lowest_low = 2'd1;
        end else if (!v[2]) begin
            lowest_low = 2'd2;
        end
    endfunction

    // Enables are always contiguous from rail 0, so drop the top one.
    function automatic logic [3:0] drop_top(input logic [3:0] v);
        drop_top = 4'b0000;
        if (v[3]) begin
            drop_top = {1'b0, v[2:0]};
        end else if (v[2]) begin
            drop_top = {2'b00, v[1:0]};
        end else if (v[1]) begin
            drop_top = {3'b000, v[0]};
        end
    endfunction

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 32'd1;
    assign en_drop = drop_top(en_q);

    // Two-flop synchronizer for the asynchronous power-good inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pg_m <= 4'b0000;
            pg_s <= 4'b0000;
        end else begin
            pg_m <= pg;
            pg_s <= pg_m;
        end
    end

    // Sequencer registers, including the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            en_q    <= 4'b0000;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            stage_q <= 2'd0;
            k_q     <= 2'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic; a trip overrides the state's own plan.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        ready_d  = ready_q;
        fault_d  = fault_q;
        stage_d  = stage_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        trip     = 1'b0;
        trip_idx = 2'd0;
        seen     = 4'b1111;
        unique case (state_q)
            IDLE: begin
                k_d     = 2'd0;
                cnt_d   = 32'd0;
                state_d = ENABLE;
            end
            ENABLE: begin
                en_d    = en_q | (4'b0001 << k_q);
                cnt_d   = 32'd0;
                state_d = WAIT_PG;
            end
            WAIT_PG: begin
                seen = pg_s | ~below_mask(k_q);
                if (seen != 4'b1111) begin
                    trip     = 1'b1;
                    trip_idx = lowest_low(seen);
                end else if (pg_s[k_q]) begin
                    cnt_d   = 32'd0;
                    state_d = SETTLE;
                end else if (cnt_q == TMO_LAST) begin
                    trip     = 1'b1;
                    trip_idx = k_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SETTLE: begin
                seen = pg_s | ~upto_mask(k_q);
                if (seen != 4'b1111) begin
                    trip     = 1'b1;
                    trip_idx = lowest_low(seen);
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d = 32'd0;
                    if (k_q == 2'd3) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = ENABLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                ready_d = 1'b1;
                if (pg_s != 4'b1111) begin
                    trip     = 1'b1;
                    trip_idx = lowest_low(pg_s);
                end
            end
            SHUTDOWN: begin
                if (cnt_q == STEP_LAST) begin
                    en_d  = en_drop;
                    cnt_d = 32'd0;
                    if (en_drop == 4'b0000) begin
                        state_d = FAULT;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FAULT: begin
                en_d    = 4'b0000;
                ready_d = 1'b0;
                fault_d = 1'b1;
                if (retry) begin
                    fault_d = 1'b0;
                    stage_d = 2'd0;
                    k_d     = 2'd0;
                    cnt_d   = 32'd0;
                    state_d = ENABLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (trip) begin
            fault_d = 1'b1;
            stage_d = trip_idx;
            ready_d = 1'b0;
            en_d    = en_drop;
            cnt_d   = 32'd0;
            state_d = (en_drop == 4'b0000) ? FAULT : SHUTDOWN;
        end
    end

    assign en          = en_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign fault_stage = stage_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Directed and randomized checks of pwr_seq against a rail-count model
// that tracks enabled rails, elapsed time per phase and pg history.
module tb_pwr_seq;

    localparam int STEP = 4;
    localparam int TMO  = 16;

    typedef enum int {M_IDLE, M_ON, M_WAIT, M_SETTLE, M_RUN, M_DOWN, M_HALT} mode_e;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       retry = 1'b0;
    logic [3:0] pg = 4'b0000;
    logic [3:0] en;
    logic       ready;
    logic       fault;
    logic [1:0] fault_stage;

    int n_chk  = 0;
    int n_pass = 0;

    mode_e      m_mode  = M_IDLE;
    int         m_rails = 0;
    int         m_k     = 0;
    int         m_t     = 0;
    bit         m_ready = 1'b0;
    bit         m_fault = 1'b0;
    int         m_stage = 0;
    logic [3:0] m_h1    = 4'b0000;
    logic [3:0] m_h2    = 4'b0000;

    int         dly[4];
    int         age[4];
    logic [3:0] force_hi = 4'b0000;
    logic [3:0] force_lo = 4'b0000;

    pwr_seq #(
        .MAIN_CLOCK_PERIOD(32'd7),
        .STEP_DELAY(32'd28),
        .PG_TIMEOUT(32'd112)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pg(pg),
        .retry(retry),
        .en(en),
        .ready(ready),
        .fault(fault),
        .fault_stage(fault_stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] m_en();
        return 4'((1 << m_rails) - 1);
    endfunction

    function automatic int first_low(input logic [3:0] v, input int top);
        for (int i = 0; i <= top; i++) if (!v[i]) return i;
        return -1;
    endfunction

    task automatic m_trip(input int j);
        m_fault = 1'b1;
        m_stage = j;
        m_ready = 1'b0;
        m_rails = m_rails - 1;
        m_t     = 0;
        m_mode  = (m_rails == 0) ? M_HALT : M_DOWN;
    endtask

    task automatic m_step();
        logic [3:0] s;
        int j;
        if (!rst) begin
            m_mode = M_IDLE; m_rails = 0; m_k = 0; m_t = 0;
            m_ready = 1'b0; m_fault = 1'b0; m_stage = 0;
            m_h1 = 4'b0000; m_h2 = 4'b0000;
            return;
        end
        s = m_h2;
        m_h2 = m_h1;
        m_h1 = pg;
        case (m_mode)
            M_IDLE: begin m_mode = M_ON; m_k = 0; end
            M_ON: begin m_rails = m_k + 1; m_t = 0; m_mode = M_WAIT; end
            M_WAIT: begin
                j = first_low(s, m_k - 1);
                if (j >= 0) m_trip(j);
                else if (s[m_k]) begin m_mode = M_SETTLE; m_t = 0; end
                else if (m_t + 1 == TMO) m_trip(m_k);
                else m_t++;
            end
            M_SETTLE: begin
                j = first_low(s, m_k);
                if (j >= 0) m_trip(j);
                else if (m_t + 1 == STEP) begin
                    m_t = 0;
                    if (m_k == 3) begin m_mode = M_RUN; m_ready = 1'b1; end
                    else begin m_k++; m_mode = M_ON; end
                end else m_t++;
            end
            M_RUN: begin
                j = first_low(s, 3);
                if (j >= 0) m_trip(j);
            end
            M_DOWN: begin
                m_t++;
                if (m_t == STEP) begin
                    m_rails--;
                    m_t = 0;
                    if (m_rails == 0) m_mode = M_HALT;
                end
            end
            M_HALT: begin
                if (retry) begin
                    m_fault = 1'b0; m_stage = 0; m_k = 0; m_mode = M_ON;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic cycle(input bit glitch);
        logic [3:0] a;
        logic [3:0] e;
        for (int i = 0; i < 4; i++) a[i] = (age[i] >= dly[i]);
        pg = (a | force_hi) & ~force_lo;
        if (glitch) begin
            pg[0] = 1'b0;
            #2;
            pg[0] = 1'b1;
        end
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("outs", {24'd0, en, ready, fault, fault_stage},
            {24'd0, m_en(), m_ready, m_fault, 2'(m_stage)});
        retry = 1'b0;
        e = m_en();
        for (int i = 0; i < 4; i++) age[i] = e[i] ? age[i] + 1 : 0;
    endtask

    task automatic step();
        cycle(1'b0);
    endtask

    task automatic run_until_ready(input string tag);
        int n;
        n = 0;
        while (!m_ready && n < 300) begin step(); n++; end
        chk(tag, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        logic [3:0] seen[$];
        logic [3:0] boot_exp[4];
        int n;
        int r;
        boot_exp[0] = 4'b0001; boot_exp[1] = 4'b0011;
        boot_exp[2] = 4'b0111; boot_exp[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin dly[i] = 5; age[i] = 0; end
        @(negedge clk);

        // reset and normal bring-up
        rst = 1'b0;
        step(); step();
        chk("rst_outs", {24'd0, en, ready, fault, fault_stage}, 32'd0);
        rst = 1'b1;
        step();
        chk("en_edge1", {28'd0, en}, 32'd0);
        step();
        chk("en_edge2", {28'd0, en}, 32'd1);
        seen.push_back(en);
        n = 0;
        while (!m_ready && n < 300) begin
            step();
            n++;
            if (en !== seen[$]) seen.push_back(en);
        end
        chk("boot_steps", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) chk("boot_en", {28'd0, seen[i]}, {28'd0, boot_exp[i]});
        chk("boot_ready", {31'd0, ready}, 32'd1);
        chk("boot_fault", {31'd0, fault}, 32'd0);

        // power-good timeout on rail 2
        rst = 1'b0; step(); rst = 1'b1;
        force_lo = 4'b0100;
        n = 0;
        while (en !== 4'b0111 && n < 200) begin step(); n++; end
        chk("tmo_en", {28'd0, en}, 32'd7);
        n = 0;
        while (fault !== 1'b1 && n < 40) begin step(); n++; end
        chk("tmo_cycles", n, 16);
        chk("tmo_stage", {30'd0, fault_stage}, 32'd2);
        chk("tmo_en_entry", {28'd0, en}, 32'd3);
        repeat (4) step();
        chk("tmo_en_step1", {28'd0, en}, 32'd1);
        repeat (4) step();
        chk("tmo_en_step2", {28'd0, en}, 32'd0);
        repeat (10) step();
        chk("tmo_hold", {24'd0, en, ready, fault, fault_stage}, 32'h06);

        // retry from FAULT, then retry ignored in RUN
        force_lo = 4'b0000;
        force_hi = 4'b1111;
        retry = 1'b1;
        step();
        chk("retry_fault", {31'd0, fault}, 32'd0);
        chk("retry_stage", {30'd0, fault_stage}, 32'd0);
        step();
        chk("retry_en0", {28'd0, en}, 32'd1);
        run_until_ready("retry_ready");
        retry = 1'b1;
        step();
        chk("run_retry", {28'd0, en, ready, fault}, 32'h3E);
        force_hi = 4'b0000;
        repeat (3) step();

        // pg[1] drop in RUN
        force_lo = 4'b0010;
        step(); step();
        chk("drop_ready2", {31'd0, ready}, 32'd1);
        step();
        chk("drop_ready3", {31'd0, ready}, 32'd0);
        chk("drop_stage", {30'd0, fault_stage}, 32'd1);
        chk("drop_en0", {28'd0, en}, 32'd7);
        repeat (4) step();
        chk("drop_en1", {28'd0, en}, 32'd3);
        repeat (4) step();
        chk("drop_en2", {28'd0, en}, 32'd1);
        repeat (4) step();
        chk("drop_en3", {28'd0, en, ready, fault}, 32'd1);
        force_lo = 4'b0000;

        // reset during SETTLE of rail 2
        rst = 1'b0; step(); rst = 1'b1;
        n = 0;
        while (!(m_mode == M_SETTLE && m_k == 2) && n < 200) begin step(); n++; end
        chk("settle2_en", {28'd0, en}, 32'd7);
        rst = 1'b0;
        step();
        chk("mid_rst", {24'd0, en, ready, fault, fault_stage}, 32'd0);
        rst = 1'b1;
        step();
        chk("mid_rst_e1", {28'd0, en}, 32'd0);
        step();
        chk("mid_rst_e2", {28'd0, en}, 32'd1);

        // glitch filter on pg[0]
        run_until_ready("glitch_ready");
        cycle(1'b1);
        repeat (4) step();
        chk("glitch_short", {30'd0, ready, fault}, 32'd2);
        force_lo = 4'b0001;
        repeat (3) step();
        force_lo = 4'b0000;
        step(); step();
        chk("glitch_long", {29'd0, fault, fault_stage}, 32'd4);

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            force_hi = 4'($urandom);
            force_lo = 4'b0000;
            for (int i = 0; i < 4; i++) dly[i] = $urandom_range(1, 17);
            if ($urandom_range(0, 3) == 0) begin rst = 1'b0; step(); end
            for (int c = 0; c < 200; c++) begin
                r = $urandom_range(0, 99);
                if (r < 3) force_lo = 4'(1 << $urandom_range(0, 3));
                else if (r < 15) force_lo = 4'b0000;
                if ($urandom_range(0, 19) == 0) retry = 1'b1;
                rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 49) == 0) cycle(1'b1);
                else step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
